// File: rtl/iic_pkg.sv
// iic_pkg: shared arbiter state encoding and default widths/limits for the IIC bus slice.
package iic_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_START,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    localparam int IIC_ADDR_W = 16;
    localparam int IIC_DATA_W = 16;
    localparam logic [23:0] IIC_TIMEOUT_DEFAULT = 24'd2_000_000;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector; searches from last+1 upward, wrapping at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    // Walk the offsets from farthest to nearest so the nearest valid requester overwrites.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[IDX_W'((int'(last) + k) % NUM_REQ)])
                idx = IDX_W'((int'(last) + k) % NUM_REQ);
        grant = '0;
        grant[idx] = |req;
    end

endmodule

// File: rtl/iic_arbiter.sv
// iic_arbiter: round-robin sequencer sharing one iic_drive among NUM_REQ requesters.
// Define IIC_ARB_TIMEOUT_EN to add a START/BUSY watchdog of TIMEOUT_CYCLES.
module iic_arbiter
    import iic_pkg::*;
#(
    parameter int          NUM_REQ        = 3,
    parameter int          ADDR_W         = IIC_ADDR_W,
    parameter int          DATA_W         = IIC_DATA_W,
    parameter logic [23:0] TIMEOUT_CYCLES = IIC_TIMEOUT_DEFAULT
) (
    input  logic                      arb_clk,
    input  logic                      arb_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw_flag,
    input  logic [NUM_REQ*ADDR_W-1:0] req_word_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      req_ack_error,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_rdata_valid,
    output logic                      iic_start,
    output logic                      iic_rw_flag,
    output logic [ADDR_W-1:0]         iic_word_addr,
    output logic [DATA_W-1:0]         iic_wdata,
    input  logic                      iic_ready,
    input  logic [DATA_W-1:0]         iic_rdata,
    input  logic                      iic_rdata_valid,
    input  logic                      iic_ack_error
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state, state_next;
    logic [IDX_W-1:0]   last, pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               sticky, active, take, timeout;

    assign active = state == ARB_START || state == ARB_BUSY;
    assign take   = state == ARB_IDLE && state_next == ARB_GRANT;

`ifdef IIC_ARB_TIMEOUT_EN
    logic [23:0] cnt;
    assign timeout = active && cnt == TIMEOUT_CYCLES - 24'd1;
    always_ff @(posedge arb_clk or posedge arb_rst)
        if (arb_rst) cnt <= '0;
        else         cnt <= active ? cnt + 24'd1 : '0;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req_valid),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_ff @(posedge arb_clk or posedge arb_rst)
        if (arb_rst) state <= ARB_IDLE;
        else         state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  state_next = (|req_valid && iic_ready) ? ARB_GRANT : ARB_IDLE;
            ARB_GRANT: state_next = ARB_START;
            ARB_START: state_next = timeout ? ARB_DONE : (!iic_ready ? ARB_BUSY : ARB_START);
            ARB_BUSY:  state_next = (timeout || iic_ready) ? ARB_DONE : ARB_BUSY;
            default:   state_next = ARB_IDLE;
        endcase
    end

    // Command fields are captured only at the IDLE->GRANT step; later field changes are ignored.
    always_ff @(posedge arb_clk or posedge arb_rst)
        if (arb_rst) begin
            last            <= IDX_W'(NUM_REQ - 1);
            req_grant       <= '0;
            req_done        <= '0;
            req_ack_error   <= 1'b0;
            req_rdata       <= '0;
            req_rdata_valid <= '0;
            iic_start       <= 1'b0;
            iic_rw_flag     <= 1'b0;
            iic_word_addr   <= '0;
            iic_wdata       <= '0;
            sticky          <= 1'b0;
        end else begin
            req_done        <= '0;
            req_rdata_valid <= '0;
            req_ack_error   <= 1'b0;
            iic_start       <= state_next == ARB_START;
            if (take) begin
                req_grant     <= pick_grant;
                last          <= pick_idx;
                iic_rw_flag   <= req_rw_flag[pick_idx];
                iic_word_addr <= req_word_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
                iic_wdata     <= req_wdata[int'(pick_idx) * DATA_W +: DATA_W];
            end
            if (active) begin
                sticky <= sticky | iic_ack_error;
                if (iic_rdata_valid) begin
                    req_rdata       <= iic_rdata;
                    req_rdata_valid <= req_grant;
                end
                if (state_next == ARB_DONE) begin
                    req_done      <= req_grant;
                    req_ack_error <= sticky | iic_ack_error | timeout;
                end
            end
            if (state == ARB_DONE) begin
                req_grant <= '0;
                sticky    <= 1'b0;
            end
        end

endmodule
